// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg
//   Shared CP0 definitions: register numbers, Status bit indices, Cause field
//   ranges, mtc0 write masks, reset constants and a masked-merge helper.
//   Optional feature macro used by the users of this package: CP0_TIMER_EN.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_ERL = 2;

  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_SW_LO  = 8;
  localparam int CAUSE_SW_HI  = 9;

  localparam logic [31:0] STATUS_WR_MASK = 32'h0000_FF07;
  localparam logic [31:0] COMPARE_RST    = 32'hFFFF_FFFF;

  function automatic logic [31:0] merge_masked(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// cp0_timer
//   Count/Compare timer. Count free-runs (+1 per cycle, wraps); an mtc0 to
//   Count overrides the increment. timer_pend is sticky, set in any cycle
//   where Count equals Compare, cleared only by an mtc0 to Compare.
//   Instantiated by cp0_regfile only when CP0_TIMER_EN is defined.
// Ports
//   clk, res        clock, async active-high reset
//   count_we        mtc0 to Count this cycle
//   compare_we      mtc0 to Compare this cycle
//   wr_data         mtc0 data
//   count, compare  current register values
//   timer_pend      sticky timer interrupt
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      count      <= '0;
      compare    <= COMPARE_RST;
      timer_pend <= 1'b0;
    end else begin
      count <= count_we ? wr_data : count + 32'd1;
      if (compare_we)
        compare <= wr_data;
      // Writing Compare acknowledges the interrupt and beats a same-cycle match.
      if (compare_we)
        timer_pend <= 1'b0;
      else if (count == compare)
        timer_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile
//   Coprocessor-0 register file: Status, Cause, EPC, BadVAddr, Count,
//   Compare, PRId. Takes exception-entry writes, mfc0/mtc0 and eret, and
//   feeds Status/Cause/irq back to the exception priority encoder.
//   Per-register write priority: exception entry > eret > mtc0.
//   Optional macro CP0_TIMER_EN: adds Count/Compare timer (cp0_timer);
//   without it Count/Compare read 0 and timer_pend is 0.
// Ports
//   clk, res                 clock, async active-high reset
//   rd_addr / rd_data        mfc0 (combinational, no write bypass)
//   wr_en/wr_addr/wr_data    mtc0
//   exc_we_* / exc_*         exception-entry writes
//   eret                     exception return strobe
//   hw_irq                   async external interrupt lines
//   cp0_status/cause/epc     register outputs
//   irq                      {timer_pend, hw_sync, Cause[9:8]}
module cp0_regfile #(
  parameter logic [31:0] PRID       = 32'h0001_8000,
  parameter logic        RST_PC_EXL = 1'b1
) (
  input  logic        clk,
  input  logic        res,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        exc_we_status,
  input  logic        exc_we_cause,
  input  logic        exc_we_epc,
  input  logic        exc_we_badvaddr,
  input  logic [31:0] exc_status,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [4:0]  hw_irq,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic [7:0]  irq
);
  import cp0_regfile_pkg::*;

  logic [31:0] status;
  logic [1:0]  cause_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [4:0]  hw_meta;
  logic [4:0]  hw_sync;
  logic [31:0] count;
  logic [31:0] compare;
  logic        timer_pend;

  logic mtc0_status, mtc0_cause, mtc0_epc;
  logic unused_exc_cause;

  assign mtc0_status = wr_en && (wr_addr == CP0_STATUS);
  assign mtc0_cause  = wr_en && (wr_addr == CP0_CAUSE);
  assign mtc0_epc    = wr_en && (wr_addr == CP0_EPC);

  // IP bits are live state; only ExcCode comes from the exception encoder.
  assign unused_exc_cause = ^{exc_cause[31:CAUSE_EXC_HI+1], exc_cause[CAUSE_EXC_LO-1:0]};

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      status <= {29'b0, RST_PC_EXL, 2'b0};
    end else if (exc_we_status) begin
      status <= exc_status;
    end else if (eret) begin
      if (status[STATUS_ERL])
        status[STATUS_ERL] <= 1'b0;
      else
        status[STATUS_EXL] <= 1'b0;
    end else if (mtc0_status) begin
      status <= merge_masked(status, wr_data, STATUS_WR_MASK);
    end
  end

  // Cause is one register: an exception write drops a same-cycle mtc0 Cause.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      exc_code <= '0;
      cause_sw <= '0;
    end else if (exc_we_cause) begin
      exc_code <= exc_cause[CAUSE_EXC_HI:CAUSE_EXC_LO];
    end else if (mtc0_cause) begin
      cause_sw <= wr_data[CAUSE_SW_HI:CAUSE_SW_LO];
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      if (exc_we_epc)
        epc <= exc_epc;
      else if (mtc0_epc)
        epc <= wr_data;
      if (exc_we_badvaddr)
        badvaddr <= exc_badvaddr;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hw_meta <= '0;
      hw_sync <= '0;
    end else begin
      hw_meta <= hw_irq;
      hw_sync <= hw_meta;
    end
  end

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .res        (res),
    .count_we   (wr_en && (wr_addr == CP0_COUNT)),
    .compare_we (wr_en && (wr_addr == CP0_COMPARE)),
    .wr_data    (wr_data),
    .count      (count),
    .compare    (compare),
    .timer_pend (timer_pend)
  );
`else
  assign count      = '0;
  assign compare    = '0;
  assign timer_pend = 1'b0;
`endif

  assign cp0_status = status;
  assign cp0_cause  = {16'b0, timer_pend, hw_sync, cause_sw, 1'b0, exc_code, 2'b0};
  assign cp0_epc    = epc;
  assign irq        = {timer_pend, hw_sync, cause_sw};

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CP0_BADVADDR: rd_data = badvaddr;
      CP0_COUNT:    rd_data = count;
      CP0_COMPARE:  rd_data = compare;
      CP0_STATUS:   rd_data = status;
      CP0_CAUSE:    rd_data = cp0_cause;
      CP0_EPC:      rd_data = epc;
      CP0_PRID:     rd_data = PRID;
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile
//   Self-checking bench for cp0_regfile: directed steps followed by random
//   traffic, all checked against a rule-level model of the CP0 registers.
//   Follows CP0_TIMER_EN the same way the design does.
module tb_cp0_regfile;
  localparam logic [31:0] PRID = 32'h0001_8000;
`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        exc_we_status = 1'b0, exc_we_cause = 1'b0, exc_we_epc = 1'b0, exc_we_badvaddr = 1'b0;
  logic [31:0] exc_status = '0, exc_cause = '0, exc_epc = '0, exc_badvaddr = '0;
  logic        eret = 1'b0;
  logic [4:0]  hw_irq = '0;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic [7:0]  irq;

  cp0_regfile #(.PRID(PRID), .RST_PC_EXL(1'b1)) dut (
    .clk(clk), .res(res),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .exc_we_status(exc_we_status), .exc_we_cause(exc_we_cause),
    .exc_we_epc(exc_we_epc), .exc_we_badvaddr(exc_we_badvaddr),
    .exc_status(exc_status), .exc_cause(exc_cause),
    .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .hw_irq(hw_irq),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: named register contents, not the RTL's flops.
  logic [31:0] m_status, m_epc, m_bad, m_count, m_cmp;
  logic [1:0]  m_sw;
  logic [4:0]  m_exc;
  logic        m_pend;
  logic [4:0]  m_hist [2];   // hw_irq as sampled at the last two edges, [1] is older

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cause();
    return {16'h0, m_pend, m_hist[1], m_sw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return TIMER ? m_count : 32'h0;
      5'd11:   return TIMER ? m_cmp : 32'h0;
      5'd12:   return m_status;
      5'd13:   return exp_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h4; m_epc = '0; m_bad = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF;
    m_sw = '0; m_exc = '0; m_pend = 1'b0; m_hist[0] = '0; m_hist[1] = '0;
  endtask

  task automatic model_edge();
    logic [31:0] ns;
    ns = m_status;
    if (exc_we_status) ns = exc_status;
    else if (eret) begin
      if (m_status[2]) ns[2] = 1'b0; else ns[1] = 1'b0;
    end else if (wr_en && wr_addr == 5'd12)
      ns = (m_status & ~32'h0000_FF07) | (wr_data & 32'h0000_FF07);
    m_status = ns;
    if (exc_we_cause) m_exc = exc_cause[6:2];
    else if (wr_en && wr_addr == 5'd13) m_sw = wr_data[9:8];
    if (exc_we_epc) m_epc = exc_epc;
    else if (wr_en && wr_addr == 5'd14) m_epc = wr_data;
    if (exc_we_badvaddr) m_bad = exc_badvaddr;
    if (TIMER) begin
      if (wr_en && wr_addr == 5'd11) m_pend = 1'b0;
      else if (m_count == m_cmp) m_pend = 1'b1;
      m_count = (wr_en && wr_addr == 5'd9) ? wr_data : m_count + 32'd1;
      if (wr_en && wr_addr == 5'd11) m_cmp = wr_data;
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = hw_irq;
  endtask

  task automatic idle();
    wr_en = 1'b0; eret = 1'b0;
    exc_we_status = 1'b0; exc_we_cause = 1'b0; exc_we_epc = 1'b0; exc_we_badvaddr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  // Called from negedge time: check the read port, clock once, check registers.
  task automatic tick();
    #1;
    chk("rd_data", rd_data, exp_rd(rd_addr));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("status", cp0_status, m_status);
    chk("cause", cp0_cause, exp_cause());
    chk("epc", cp0_epc, m_epc);
    chk("irq", {24'h0, irq}, {24'h0, m_pend, m_hist[1], m_sw});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    res = 1'b0;
    model_reset();
    #1;
    chk("rst_status", cp0_status, 32'h4);
    chk("rst_cause", cp0_cause, 32'h0);
    chk("rst_irq", {24'h0, irq}, 32'h0);
    rd_addr = 5'd15;
    #1 chk("rst_prid", rd_data, PRID);

    // mtc0 masks
    mtc0(5'd12, 32'hFFFF_FFFF); tick();
    chk("status_mask", cp0_status, 32'h0000_FF07);
    mtc0(5'd13, 32'hFFFF_FFFF); tick();
    chk("cause_mask", cp0_cause, 32'h0000_0300);
    chk("irq_sw", {24'h0, irq}, 32'h03);
    mtc0(5'd15, 32'h1234_5678); tick();
    mtc0(5'd8, 32'h1234_5678); rd_addr = 5'd8; tick();
    chk("badvaddr_ro", rd_data, 32'h0);

    // exception entry beats same-cycle mtc0 Status
    mtc0(5'd12, 32'h0);
    exc_we_status = 1'b1; exc_status = 32'h2;
    exc_we_cause = 1'b1; exc_cause = 32'h0000_FF20;
    exc_we_epc = 1'b1; exc_epc = 32'h80;
    exc_we_badvaddr = 1'b1; exc_badvaddr = 32'hDEAD_0000;
    rd_addr = 5'd12;
    tick();
    idle();
    chk("exc_status", cp0_status, 32'h2);
    chk("exc_code", {27'h0, cp0_cause[6:2]}, 32'd8);
    chk("exc_epc", cp0_epc, 32'h80);
    rd_addr = 5'd8;
    #1 chk("exc_badvaddr", rd_data, 32'hDEAD_0000);

    // eret
    mtc0(5'd12, 32'h6); tick(); idle();
    eret = 1'b1; tick();
    chk("eret_erl", cp0_status, 32'h2);
    tick();
    chk("eret_exl", cp0_status, 32'h0);
    exc_we_status = 1'b1; exc_status = 32'h2; tick(); idle();
    chk("eret_vs_exc", cp0_status, 32'h2);

    // hw_irq synchroniser latency
    hw_irq = 5'b00001; tick();
    chk("hw_rise_1", {31'h0, irq[2]}, 32'h0);
    tick();
    chk("hw_rise_2", {31'h0, irq[2]}, 32'h1);
    chk("hw_cause10", {31'h0, cp0_cause[10]}, 32'h1);
    hw_irq = 5'b00000; tick();
    chk("hw_fall_1", {31'h0, irq[2]}, 32'h1);
    tick();
    chk("hw_fall_2", {31'h0, irq[2]}, 32'h0);

    // timer
    if (TIMER) begin
      mtc0(5'd11, 32'h1); tick();
      mtc0(5'd9, 32'hFFFF_FFFE); tick(); idle();
      tick(); tick();
      rd_addr = 5'd9;
      #1 chk("count_wrap", rd_data, 32'h0);
      tick();
      chk("pend_before", {31'h0, irq[7]}, 32'h0);
      tick();
      chk("pend_set", {31'h0, irq[7]}, 32'h1);
      repeat (3) tick();
      chk("pend_hold", {31'h0, irq[7]}, 32'h1);
      mtc0(5'd11, 32'h1000_0000); tick(); idle();
      chk("pend_clear", {31'h0, irq[7]}, 32'h0);
    end else begin
      mtc0(5'd9, 32'h5); tick();
      mtc0(5'd11, 32'h0); tick(); idle();
      rd_addr = 5'd9;
      #1 chk("count_absent", rd_data, 32'h0);
      chk("pend_absent", {31'h0, irq[7]}, 32'h0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] addr_pool [8];
      addr_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
      addr_pool[7] = 5'($urandom);
      rd_addr = addr_pool[$urandom_range(0, 7)];
      wr_en = ($urandom_range(0, 1) == 1);
      wr_addr = addr_pool[$urandom_range(0, 7)];
      wr_data = $urandom;
      exc_we_status = ($urandom_range(0, 7) == 0);
      exc_we_cause = ($urandom_range(0, 7) == 0);
      exc_we_epc = ($urandom_range(0, 7) == 0);
      exc_we_badvaddr = ($urandom_range(0, 7) == 0);
      exc_status = $urandom; exc_cause = $urandom;
      exc_epc = $urandom; exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 5) == 0);
      hw_irq = 5'($urandom);
      tick();
    end
    idle();

    // asynchronous reset mid-operation, no clock edge involved
    hw_irq = 5'b10101;
    mtc0(5'd14, 32'hCAFE_0004); tick(); idle();
    #1 res = 1'b1;
    #1;
    chk("async_status", cp0_status, 32'h4);
    chk("async_cause", cp0_cause, 32'h0);
    chk("async_epc", cp0_epc, 32'h0);
    chk("async_irq", {24'h0, irq}, 32'h0);
    #1 res = 1'b0;
    model_reset();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
